// File: rtl/multicycle_ctrl_fsm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : riscv_ctrl_pkg                                                   |
// | Brief   : Shared encodings for the multicycle RV32I control path: FSM      |
// |           state codes, opcodes, ALUOp codes, alu_control codes and         |
// |           imm_src codes.                                                   |
// | Ports   : none (package)                                                   |
// | Config  : MC_CTRL_JAL_EN enables the jal path in the FSM (OP_JAL and       |
// |           ST_JAL are always declared here).                                |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package riscv_ctrl_pkg;

  // State encodings (4 bits); the FSM widens them to its STATE_W.
  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_DECODE   = 4'd1;
  localparam logic [3:0] ST_MEMADR   = 4'd2;
  localparam logic [3:0] ST_MEMREAD  = 4'd3;
  localparam logic [3:0] ST_MEMWRITE = 4'd4;
  localparam logic [3:0] ST_MEMWB    = 4'd5;
  localparam logic [3:0] ST_EXECUTER = 4'd6;
  localparam logic [3:0] ST_EXECUTEI = 4'd7;
  localparam logic [3:0] ST_ALUWB    = 4'd8;
  localparam logic [3:0] ST_BEQ      = 4'd9;
  localparam logic [3:0] ST_JAL      = 4'd10;

  // Opcodes (instruction[6:0])
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // ALUOp from FSM to ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // alu_control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // imm_src codes
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage : riscv_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : multicycle_ctrl_fsm_if                                         |
// | Brief     : Bundle between the control FSM and the multicycle datapath.    |
// |             master = control FSM, slave = datapath.                        |
// | Signals   : op[6:0], funct3[2:0], funct7b5, zero, mem_ready   (to FSM)     |
// |             pc_write, adr_src, mem_write, ir_write, result_src[1:0],       |
// |             alu_src_a[1:0], alu_src_b[1:0], reg_write, imm_src[1:0],       |
// |             alu_control[2:0], illegal_instr                 (from FSM)     |
// | Config    : none                                                         |
// | Rev       : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface multicycle_ctrl_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic       reg_write;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal_instr;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, reg_write, imm_src, alu_control,
           illegal_instr
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, reg_write, imm_src, alu_control,
           illegal_instr
  );
endinterface : multicycle_ctrl_fsm_if
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm_alu_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : alu_decoder                                                       |
// | Brief  : Combinational ALU control decode from ALUOp and IR fields.        |
// | Ports  : aluop[1:0]       in  ALUOp from the control FSM                   |
// |          funct3[2:0]      in  instruction[14:12]                           |
// |          op_b5            in  instruction[5] (R-type vs I-type)            |
// |          funct7b5         in  instruction[30]                              |
// |          alu_control[2:0] out ALU operation select                         |
// | Config : none                                                             |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [2:0] funct3,
  input  logic       op_b5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7b5 only selects sub for R-type; addi's imm[10] must not.
          3'b000:  alu_control = (op_b5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : multicycle_ctrl_fsm                                               |
// | Brief  : Moore control FSM for the multicycle RV32I datapath. Steps each   |
// |          instruction FETCH..writeback and drives all datapath selects and  |
// |          write enables, plus imm_src and alu_control from IR fields.       |
// | Ports  : clk      in  rising-edge clock                                    |
// |          reset    in  asynchronous active-high reset                       |
// |          bus      multicycle_ctrl_fsm_if.master (IR fields, zero,          |
// |                   mem_ready in; datapath controls, illegal_instr out)      |
// | Params : MEM_HANDSHAKE 1: memory states wait for mem_ready; 0: ignore it   |
// |          STATE_W       state register width (>= 4)                         |
// | Config : MC_CTRL_JAL_EN adds the JAL state and imm_src=J decode for jal;   |
// |          when undefined jal is treated as an illegal opcode.               |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int STATE_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_ctrl_fsm_if.master bus
);

  // A STATE_W below 4 truncates the codes into duplicates and fails elaboration.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(ST_FETCH),
    S_DECODE   = STATE_W'(ST_DECODE),
    S_MEMADR   = STATE_W'(ST_MEMADR),
    S_MEMREAD  = STATE_W'(ST_MEMREAD),
    S_MEMWRITE = STATE_W'(ST_MEMWRITE),
    S_MEMWB    = STATE_W'(ST_MEMWB),
    S_EXECUTER = STATE_W'(ST_EXECUTER),
    S_EXECUTEI = STATE_W'(ST_EXECUTEI),
    S_ALUWB    = STATE_W'(ST_ALUWB),
    S_BEQ      = STATE_W'(ST_BEQ),
    S_JAL      = STATE_W'(ST_JAL)
  } state_t;

  state_t     r_state;
  state_t     w_next;
  aluop_t     w_aluop;
  logic       w_mem_ok;
  logic       w_branch;
  logic       w_pc_update;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_write;
  logic       w_adr_src;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic       w_illegal;
  logic [1:0] w_imm_src;

  assign w_mem_ok = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = S_FETCH;
    w_aluop      = ALUOP_ADD;
    w_branch     = 1'b0;
    w_pc_update  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_write  = 1'b0;
    w_adr_src    = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_illegal    = 1'b0;
    case (r_state)
      S_FETCH: begin
        // PC+4 goes straight from ALUResult into the PC while the IR loads.
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = w_mem_ok;
        w_pc_update  = w_mem_ok;
        w_next       = w_mem_ok ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECUTER;
          OP_I:         w_next = S_EXECUTEI;
          OP_BEQ:       w_next = S_BEQ;
`ifdef MC_CTRL_JAL_EN
          OP_JAL:       w_next = S_JAL;
`endif
          default: begin
            w_next    = S_FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_next      = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
        w_next    = w_mem_ok ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_next      = w_mem_ok ? S_FETCH : S_MEMWRITE;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_next       = S_FETCH;
      end
      S_EXECUTER: begin
        w_alu_src_a = 2'b10;
        w_aluop     = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_EXECUTEI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_aluop     = ALUOP_FUNCT;
        w_next      = S_ALUWB;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_next      = S_FETCH;
      end
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_aluop     = ALUOP_SUB;
        w_branch    = 1'b1;
        w_next      = S_FETCH;
      end
`ifdef MC_CTRL_JAL_EN
      S_JAL: begin
        // PC takes the target held in ALUOut; ALU forms OldPC+4 for ALUWB.
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
        w_next      = S_ALUWB;
      end
`endif
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_imm_src = IMM_I;
    case (bus.op)
      OP_SW:  w_imm_src = IMM_S;
      OP_BEQ: w_imm_src = IMM_B;
`ifdef MC_CTRL_JAL_EN
      OP_JAL: w_imm_src = IMM_J;
`endif
      default: w_imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (w_aluop),
    .funct3      (bus.funct3),
    .op_b5       (bus.op[5]),
    .funct7b5    (bus.funct7b5),
    .alu_control (bus.alu_control)
  );

  // Write enables are gated by reset so nothing is committed while it is held.
  assign bus.pc_write      = ~reset & (w_pc_update | (w_branch & bus.zero));
  assign bus.ir_write      = ~reset & w_ir_write;
  assign bus.reg_write     = ~reset & w_reg_write;
  assign bus.mem_write     = ~reset & w_mem_write;
  assign bus.adr_src       = w_adr_src;
  assign bus.result_src    = w_result_src;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.imm_src       = w_imm_src;
  assign bus.illegal_instr = w_illegal;

endmodule : multicycle_ctrl_fsm
`default_nettype wire

// File: tb/tb_multicycle_ctrl_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_multicycle_ctrl_fsm                                            |
// | Brief  : Directed bench for multicycle_ctrl_fsm. Each cycle's expected     |
// |          output vector is queued by the driver; a negedge monitor pops     |
// |          and compares.                                                     |
// | Config : MC_CTRL_JAL_EN selects the jal expectations.                      |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_fsm_if bus ();

  multicycle_ctrl_fsm #(
    .MEM_HANDSHAKE (1),
    .STATE_W       (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [16:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
  //  alu_src_b, reg_write, imm_src, alu_control, illegal_instr}
  logic [16:0] act;
  assign act = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.reg_write,
                bus.imm_src, bus.alu_control, bus.illegal_instr};

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      n_checks++;
      if (act !== e.exp) begin
        n_fail++;
        $display("FAIL %s: got %b, expected %b", e.name, act, e.exp);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [16:0] sig(input logic pcw, input logic adr,
      input logic mw, input logic irw, input logic [1:0] rs,
      input logic [1:0] sa, input logic [1:0] sbs, input logic rw,
      input logic [1:0] imm, input logic [2:0] alu, input logic ill);
    return {pcw, adr, mw, irw, rs, sa, sbs, rw, imm, alu, ill};
  endfunction

  function automatic logic [16:0] fetch_v(input logic [1:0] imm, input logic mr);
    return sig(mr, 1'b0, 1'b0, mr, 2'b10, 2'b00, 2'b10, 1'b0, imm, 3'b000, 1'b0);
  endfunction

  function automatic logic [16:0] decode_v(input logic [1:0] imm, input logic ill);
    return sig(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0, imm, 3'b000, ill);
  endfunction

  // One clock of stimulus: drive inputs, queue expected outputs for this cycle.
  task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic z, input logic mr, input logic [16:0] e,
                     input string n);
    bus.op        = op;
    bus.funct3    = f3;
    bus.funct7b5  = f7;
    bus.zero      = z;
    bus.mem_ready = mr;
    sb_q.push_back('{exp: e, name: n});
    @(posedge clk);
    #1;
  endtask

  task automatic run_r(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic is_i, input logic [2:0] alu, input string n);
    cyc(op, f3, f7, 1'b0, 1'b1, fetch_v(2'b00, 1'b1), {n, "_fetch"});
    cyc(op, f3, f7, 1'b0, 1'b1, decode_v(2'b00, 1'b0), {n, "_decode"});
    cyc(op, f3, f7, 1'b0, 1'b1,
        sig(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, is_i ? 2'b01 : 2'b00,
            1'b0, 2'b00, alu, 1'b0), {n, "_exec"});
    cyc(op, f3, f7, 1'b0, 1'b1,
        sig(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 1'b0),
        {n, "_aluwb"});
  endtask

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] BAD = 7'b1111111;

  logic [16:0] memadr_i, memread_v, memwb_v, memadr_s, memwr_v;

  initial begin
    memadr_i   = sig(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b00, 3'b000, 1'b0);
    memread_v  = sig(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 3'b000, 1'b0);
    memwb_v    = sig(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1, 2'b00, 3'b000, 1'b0);
    memadr_s   = sig(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0, 2'b01, 3'b000, 1'b0);
    memwr_v    = sig(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 3'b000, 1'b0);

    bus.op = RT; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0;
    bus.zero = 1'b0; bus.mem_ready = 1'b1;
    @(posedge clk);
    #1;
    // Held in reset: FETCH selects, write enables suppressed despite mem_ready.
    cyc(RT, 3'b000, 1'b0, 1'b0, 1'b1,
        sig(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0),
        "reset_fetch");
    reset = 1'b0;

    // R/I-type ALU paths
    run_r(RT, 3'b000, 1'b0, 1'b0, 3'b000, "add");
    run_r(RT, 3'b000, 1'b1, 1'b0, 3'b001, "sub");
    run_r(RT, 3'b110, 1'b0, 1'b0, 3'b011, "or");
    run_r(RT, 3'b111, 1'b0, 1'b0, 3'b010, "and");
    run_r(RT, 3'b010, 1'b0, 1'b0, 3'b101, "slt");
    run_r(IT, 3'b000, 1'b1, 1'b1, 3'b000, "addi_f7b5");
    run_r(IT, 3'b001, 1'b0, 1'b1, 3'b000, "i_f3_001");

    // lw with a fetch stall and three memory wait cycles
    cyc(LW, 3'b010, 1'b0, 1'b0, 1'b0, fetch_v(2'b00, 1'b0), "fetch_stall");
    cyc(LW, 3'b010, 1'b0, 1'b0, 1'b1, fetch_v(2'b00, 1'b1), "lw_fetch");
    cyc(LW, 3'b010, 1'b0, 1'b0, 1'b1, decode_v(2'b00, 1'b0), "lw_decode");
    cyc(LW, 3'b010, 1'b0, 1'b0, 1'b1, memadr_i, "lw_memadr");
    for (int i = 0; i < 3; i++)
      cyc(LW, 3'b010, 1'b0, 1'b0, 1'b0, memread_v, "lw_memread_wait");
    cyc(LW, 3'b010, 1'b0, 1'b0, 1'b1, memread_v, "lw_memread_done");
    cyc(LW, 3'b010, 1'b0, 1'b0, 1'b0, memwb_v, "lw_memwb");

    // sw with two memory wait cycles
    cyc(SW, 3'b010, 1'b0, 1'b0, 1'b1, fetch_v(2'b01, 1'b1), "sw_fetch");
    cyc(SW, 3'b010, 1'b0, 1'b0, 1'b1, decode_v(2'b01, 1'b0), "sw_decode");
    cyc(SW, 3'b010, 1'b0, 1'b0, 1'b1, memadr_s, "sw_memadr");
    cyc(SW, 3'b010, 1'b0, 1'b0, 1'b0, memwr_v, "sw_memwrite_wait");
    cyc(SW, 3'b010, 1'b0, 1'b0, 1'b0, memwr_v, "sw_memwrite_wait");
    cyc(SW, 3'b010, 1'b0, 1'b0, 1'b1, memwr_v, "sw_memwrite_done");

    // beq taken (zero held high throughout: only BEQ may raise pc_write from it)
    cyc(BEQ, 3'b000, 1'b0, 1'b1, 1'b1, fetch_v(2'b10, 1'b1), "beq_t_fetch");
    cyc(BEQ, 3'b000, 1'b0, 1'b1, 1'b1, decode_v(2'b10, 1'b0), "beq_t_decode");
    cyc(BEQ, 3'b000, 1'b0, 1'b1, 1'b1,
        sig(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 3'b001, 1'b0),
        "beq_taken");
    // beq not taken
    cyc(BEQ, 3'b000, 1'b0, 1'b0, 1'b1, fetch_v(2'b10, 1'b1), "beq_n_fetch");
    cyc(BEQ, 3'b000, 1'b0, 1'b0, 1'b1, decode_v(2'b10, 1'b0), "beq_n_decode");
    cyc(BEQ, 3'b000, 1'b0, 1'b0, 1'b1,
        sig(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0, 2'b10, 3'b001, 1'b0),
        "beq_not_taken");

    // Illegal opcode: pulse in DECODE, then back to FETCH
    cyc(BAD, 3'b000, 1'b0, 1'b0, 1'b1, fetch_v(2'b00, 1'b1), "bad_fetch");
    cyc(BAD, 3'b000, 1'b0, 1'b0, 1'b1, decode_v(2'b00, 1'b1), "bad_decode");

    // Reset asserted mid-instruction while in MEMREAD
    cyc(LW, 3'b010, 1'b0, 1'b0, 1'b1, fetch_v(2'b00, 1'b1), "rst_lw_fetch");
    cyc(LW, 3'b010, 1'b0, 1'b0, 1'b1, decode_v(2'b00, 1'b0), "rst_lw_decode");
    cyc(LW, 3'b010, 1'b0, 1'b0, 1'b1, memadr_i, "rst_lw_memadr");
    cyc(LW, 3'b010, 1'b0, 1'b0, 1'b0, memread_v, "rst_lw_memread");
    reset = 1'b1;
    cyc(LW, 3'b010, 1'b0, 1'b0, 1'b1,
        sig(1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 1'b0, 2'b00, 3'b000, 1'b0),
        "reset_in_memread");
    reset = 1'b0;
    run_r(RT, 3'b111, 1'b0, 1'b0, 3'b010, "after_reset");

`ifdef MC_CTRL_JAL_EN
    cyc(JAL, 3'b000, 1'b0, 1'b0, 1'b1, fetch_v(2'b11, 1'b1), "jal_fetch");
    cyc(JAL, 3'b000, 1'b0, 1'b0, 1'b1, decode_v(2'b11, 1'b0), "jal_decode");
    cyc(JAL, 3'b000, 1'b0, 1'b0, 1'b1,
        sig(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0, 2'b11, 3'b000, 1'b0),
        "jal_state");
    cyc(JAL, 3'b000, 1'b0, 1'b0, 1'b1,
        sig(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1, 2'b11, 3'b000, 1'b0),
        "jal_aluwb");
`else
    cyc(JAL, 3'b000, 1'b0, 1'b0, 1'b1, fetch_v(2'b00, 1'b1), "jal_fetch");
    cyc(JAL, 3'b000, 1'b0, 1'b0, 1'b1, decode_v(2'b00, 1'b1), "jal_illegal");
`endif
    run_r(IT, 3'b110, 1'b0, 1'b1, 3'b011, "ori_last");

    repeat (2) @(posedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_multicycle_ctrl_fsm
`default_nettype wire
